// File: rtl/mem_sum_game.sv
// mem_sum_game: memory-sum game sequencer; define GAME_SCORE_EN to enable the saturating score counter.
module mem_sum_game #(
    parameter int                 NUM_W      = 5,
    parameter logic [NUM_W-1:0]   LFSR_SEED  = 5'b10101,
    parameter logic [NUM_W-1:0]   LFSR_TAPS  = 5'b10100,
    parameter int                 N_SHOW     = 4,
    parameter int                 SHOW_CYC   = 1,
    parameter int                 INPUT_CYC  = 6,
    parameter int                 RESULT_CYC = 4,
    parameter int                 AUTO_START = 1,
    parameter int                 LED_W      = 7,
    parameter int                 SW_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             submit,
    input  logic [SW_W-1:0]  switch,
    output logic [LED_W-1:0] led,
    output logic [7:0]       disp_value,
    output logic             busy,
    output logic             round_done,
    output logic             correct,
    output logic [3:0]       score
);
    localparam int SUM_W = NUM_W + 3;
    localparam logic [NUM_W-1:0] SEED = (LFSR_SEED == '0) ? '1 : LFSR_SEED;
    localparam logic [LED_W-1:0] ALT = LED_W'({LED_W{2'b10}} >> LED_W);
    localparam logic [7:0] SHOW_LAST = 8'(SHOW_CYC - 1);
    localparam logic [7:0] INPUT_LAST = 8'(INPUT_CYC - 1);
    localparam logic [7:0] RESULT_LAST = 8'(RESULT_CYC - 1);
    localparam logic [2:0] SLOT_LAST = 3'(N_SHOW - 1);

    typedef enum logic [2:0] {IDLE, SHOW, BLANK, INPUT, RESULT, GAP} state_t;

    state_t           state;
    logic [NUM_W-1:0] lfsr;
    logic [NUM_W-1:0] number;
    logic [SUM_W-1:0] sum;
    logic [7:0]       cnt;
    logic [2:0]       slot;
    logic [7:0]       answer;
    logic             go, draw, to_result, hit;

    assign answer    = 8'(32'(sum) % 32'd100);
    assign go        = AUTO_START != 0 || start;
    assign to_result = state == INPUT && (submit || cnt == INPUT_LAST);
    assign hit       = 8'(switch) == answer;
    // a draw happens on every slot entry, including the first slot of a looping round
    assign draw = (state == IDLE && go) || (state == GAP && AUTO_START != 0) ||
                  (state == SHOW && cnt == SHOW_LAST && slot != SLOT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            number     <= '0;
            sum        <= '0;
            cnt        <= '0;
            slot       <= '0;
            led        <= '0;
            disp_value <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            correct    <= 1'b0;
        end else begin
            busy       <= state != IDLE;
            round_done <= state == RESULT && cnt == RESULT_LAST;
            disp_value <= state == SHOW   ? 8'(number) :
                          state == INPUT  ? 8'(switch) :
                          state == RESULT ? answer : 8'd0;
            led <= state == IDLE   ? '0 :
                   state == SHOW   ? LED_W'(number) << (LED_W - NUM_W) :
                   state == RESULT ? (correct ? '1 : ALT) :
                   state == GAP    ? '1 : led;
            if (draw) begin
                number <= lfsr;
                lfsr   <= {lfsr[NUM_W-2:0], ^(lfsr & LFSR_TAPS)};
                sum    <= (state == SHOW ? sum : '0) + SUM_W'(lfsr);
            end else if (state == IDLE) begin
                sum <= '0;
            end
            if (to_result)
                correct <= hit;
            case (state)
                IDLE: if (go) begin
                    state <= SHOW;
                    slot  <= '0;
                    cnt   <= '0;
                end
                SHOW: if (cnt == SHOW_LAST) begin
                    cnt   <= '0;
                    slot  <= slot + 3'd1;
                    state <= slot == SLOT_LAST ? BLANK : SHOW;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                BLANK: begin
                    state <= INPUT;
                    cnt   <= '0;
                end
                INPUT: begin
                    state <= to_result ? RESULT : INPUT;
                    cnt   <= to_result ? 8'd0 : cnt + 8'd1;
                end
                RESULT: begin
                    state <= cnt == RESULT_LAST ? GAP : RESULT;
                    cnt   <= cnt == RESULT_LAST ? 8'd0 : cnt + 8'd1;
                end
                GAP: begin
                    state <= AUTO_START != 0 ? SHOW : IDLE;
                    slot  <= '0;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GAME_SCORE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            score <= '0;
        else if (to_result && hit && score != 4'hF)
            score <= score + 4'd1;
    end
`else
    assign score = '0;
`endif
endmodule

// File: tb/tb_mem_sum_game.sv
// tb_mem_sum_game: randomized rounds checked every cycle against a round-level model of the game.
module tb_mem_sum_game;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, submit = 1'b0;
    logic [6:0] switch = '0;
    logic [6:0] led;
    logic [7:0] disp_value;
    logic       busy, round_done, correct;
    logic [3:0] score;
    logic       start_m = 1'b0, submit_m = 1'b0;
    logic [6:0] switch_m = '0;
    logic [6:0] led_m;
    logic [7:0] disp_m;
    logic       busy_m, round_done_m, correct_m;
    logic [3:0] score_m;

    mem_sum_game dut (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .switch(switch),
        .led(led), .disp_value(disp_value), .busy(busy), .round_done(round_done),
        .correct(correct), .score(score)
    );

    mem_sum_game #(.AUTO_START(0)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .submit(submit_m), .switch(switch_m),
        .led(led_m), .disp_value(disp_m), .busy(busy_m), .round_done(round_done_m),
        .correct(correct_m), .score(score_m)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 1'b0, idle_m_chk = 1'b0;
    int e_disp = 0, e_led = 0, e_busy = 0, e_rd = 0, e_cor = 0, e_score = 0;

    int mlfsr = 21, m_score = 0, m_cor = 0, mans = 0;
    int mnums[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("disp", int'(disp_value), e_disp);
            chk("led", int'(led), e_led);
            chk("busy", int'(busy), e_busy);
            chk("round_done", int'(round_done), e_rd);
            chk("correct", int'(correct), e_cor);
            chk("score", int'(score), e_score);
        end
        if (idle_m_chk) begin
            chk("m_idle_busy", int'(busy_m), 0);
            chk("m_idle_disp", int'(disp_m), 0);
        end
    end

    function automatic int lfsr_next(input int x);
        return ((x << 1) & 31) | (((x >> 4) ^ (x >> 2)) & 1);
    endfunction

    task automatic draw_round();
        int sum = 0;
        for (int i = 0; i < 4; i++) begin
            mnums[i] = mlfsr;
            sum += mlfsr;
            mlfsr = lfsr_next(mlfsr);
        end
        mans = sum % 100;
    endtask

    task automatic zero_expect();
        e_disp = 0; e_led = 0; e_busy = 0; e_rd = 0; e_cor = 0; e_score = 0;
        m_cor = 0; m_score = 0; mlfsr = 21;
    endtask

    // entered just after the clock edge that moves the DUT into SHOW
    task automatic run_round(input int sw_in, input int k, input int abort_p,
                             input int pin_ans, input int pin_led);
        int sw, len, big_l, s, hit;
        draw_round();
        sw = sw_in < 0 ? mans : sw_in;
        big_l = k != 0 ? k : 6;
        len = big_l + 10;
        hit = sw == mans ? 1 : 0;
        switch = 7'(sw);
        for (int p = 1; p <= len; p++) begin
            @(posedge clk); #1;
            if (p == abort_p) begin
                rst = 1'b1;
                submit = 1'b0;
                zero_expect();
                #1;
                chk("abort_disp", int'(disp_value), 0);
                chk("abort_led", int'(led), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_score", int'(score), 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            submit = (k != 0 && p == 4 + k);
            if (p == 5 + big_l) begin
                m_cor = hit;
`ifdef GAME_SCORE_EN
                if (hit != 0 && m_score < 15) m_score++;
`endif
            end
            s = p - 1;
            e_busy = 1;
            e_rd = s == 8 + big_l ? 1 : 0;
            if (s < 4) begin
                e_disp = mnums[s]; e_led = (mnums[s] << 2) & 127;
            end else if (s == 4) begin
                e_disp = 0; e_led = (mnums[3] << 2) & 127;
            end else if (s < 5 + big_l) begin
                e_disp = sw;
            end else if (s < 9 + big_l) begin
                e_disp = mans; e_led = m_cor != 0 ? 127 : 85;
            end else begin
                e_disp = 0; e_led = 127;
            end
            e_cor = m_cor;
            e_score = m_score;
            if (pin_ans >= 0 && s == 5 + big_l) begin
                chk("pin_result_disp", int'(disp_value), pin_ans);
                chk("pin_result_led", int'(led), pin_led);
            end
        end
    endtask

    int pin_r1[4] = '{21, 10, 20, 8};
    int pin_r2[4] = '{16, 1, 2, 4};

    initial begin
        int busy_cnt;
        zero_expect();
        chk_en = 1'b1;
        idle_m_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_round(59, 0, 0, 59, 127);
        for (int i = 0; i < 4; i++) chk("model_round1_num", mnums[i], pin_r1[i]);
        run_round(22, 0, 0, 23, 85);
        for (int i = 0; i < 4; i++) chk("model_round2_num", mnums[i], pin_r2[i]);
        run_round(0, 0, 7, -1, 0);
        run_round(59, 2, 0, 59, 127);
        repeat (12)
            run_round($urandom_range(0, 1) != 0 ? -1 : int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 6)), 0, -1, 0);
        repeat (16) run_round(-1, int'($urandom_range(0, 6)), 0, -1, 0);
`ifdef GAME_SCORE_EN
        chk("score_saturated", int'(score), 15);
`else
        chk("score_disabled", int'(score), 0);
`endif
        chk_en = 1'b0;
        idle_m_chk = 1'b0;
        switch_m = 7'd59;
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        chk("m_busy_lag", int'(busy_m), 0);
        busy_cnt = 0;
        for (int p = 1; p <= 20; p++) begin
            @(posedge clk); #1;
            start_m = p == 8;
            if (p <= 4) chk("m_show_num", int'(disp_m), pin_r1[p-1]);
            if (p == 12) begin
                chk("m_result_disp", int'(disp_m), 59);
                chk("m_correct", int'(correct_m), 1);
            end
            if (busy_m) busy_cnt++;
        end
        chk("m_busy_cycles", busy_cnt, 16);
        chk("m_idle_after", int'(busy_m), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
